// File: rtl/factorial_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
// Module      : factorial_pkg
// Description : Shared types and default widths for the factorial dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
package factorial_pkg;

    localparam int IN_DATA_WD  = 3;
    localparam int OUT_DATA_WD = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } disp_state_e;

    // Golden n! truncated to the result width, for use by benches.
    function automatic logic [OUT_DATA_WD-1:0] factorial_ref(input logic [IN_DATA_WD-1:0] n);
        logic [OUT_DATA_WD-1:0] acc;
        acc = OUT_DATA_WD'(1);
        for (int i = 2; i < (1 << IN_DATA_WD); i++) begin
            if (i <= int'(n)) begin
                acc = acc * OUT_DATA_WD'(i);
            end
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/factorial_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : factorial_dispatcher_if
// Description : Request, core and response signal bundle of the dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
interface factorial_dispatcher_if #(
    parameter int IN_DATA_WD  = factorial_pkg::IN_DATA_WD,
    parameter int OUT_DATA_WD = factorial_pkg::OUT_DATA_WD,
    parameter int DEPTH       = 4
);
    localparam int CNT_WD = $clog2(DEPTH + 1);

    logic [IN_DATA_WD-1:0]  req_data;
    logic                   req_valid;
    logic                   req_ready;
    logic [IN_DATA_WD-1:0]  core_in_data;
    logic                   core_in_valid;
    logic [OUT_DATA_WD-1:0] core_out_data;
    logic                   core_out_valid;
    logic                   core_out_busy;
    logic [OUT_DATA_WD-1:0] rsp_data;
    logic [IN_DATA_WD-1:0]  rsp_arg;
    logic                   rsp_error;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [CNT_WD-1:0]      count;

    modport slave (
        input  req_data, req_valid,
        output req_ready,
        output core_in_data, core_in_valid,
        input  core_out_data, core_out_valid, core_out_busy,
        output rsp_data, rsp_arg, rsp_error, rsp_valid,
        input  rsp_ready,
        output count
    );

    modport master (
        output req_data, req_valid,
        input  req_ready,
        input  core_in_data, core_in_valid,
        output core_out_data, core_out_valid, core_out_busy,
        input  rsp_data, rsp_arg, rsp_error, rsp_valid,
        output rsp_ready,
        input  count
    );
endinterface
`default_nettype wire

// File: rtl/factorial_dispatcher_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : factorial_req_fifo
// Description : Synchronous power-of-two FIFO holding pending arguments.
// Revision    : 1.0 - initial release
// ============================================================================
module factorial_req_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  wire logic                         clk,
    input  wire logic                         reset,
    input  wire logic                         push_i,
    input  wire logic                         pop_i,
    input  wire logic [WIDTH-1:0]             data_i,
    output logic      [WIDTH-1:0]             head_o,
    output logic      [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                              full_o,
    output logic                              empty_o
);
    localparam int PTR_WD = $clog2(DEPTH);
    localparam int CNT_WD = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_WD-1:0] wr_ptr_q;
    logic [PTR_WD-1:0] rd_ptr_q;
    logic [CNT_WD-1:0] count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CNT_WD'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push is refused while full even if a pop happens the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_WD'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_WD'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_WD'(1);
                2'b01:   count_q <= count_q - CNT_WD'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/factorial_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : factorial_dispatcher
// Description : Queues factorial arguments, issues them to the core one at a
//               time and returns tagged results with a no-answer watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module factorial_dispatcher
    import factorial_pkg::*;
#(
    parameter int IN_DATA_WD  = factorial_pkg::IN_DATA_WD,
    parameter int OUT_DATA_WD = factorial_pkg::OUT_DATA_WD,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT     = 64
) (
    input wire logic              clk,
    input wire logic              reset,
    factorial_dispatcher_if.slave disp_if
);
    localparam int CNT_WD = $clog2(DEPTH + 1);
    localparam int WD_WD  = $clog2(TIMEOUT + 1);
    localparam logic [WD_WD-1:0] WD_LIMIT = WD_WD'(TIMEOUT);

    disp_state_e            state_q,     state_d;
    logic [WD_WD-1:0]       wdog_q,      wdog_d;
    logic [OUT_DATA_WD-1:0] rsp_data_q,  rsp_data_d;
    logic [IN_DATA_WD-1:0]  rsp_arg_q,   rsp_arg_d;
    logic                   rsp_error_q, rsp_error_d;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [IN_DATA_WD-1:0]  fifo_head;
    logic [CNT_WD-1:0]      fifo_count;

    assign fifo_push = disp_if.req_valid && !fifo_full;
    assign fifo_pop  = (state_q == ISSUE);

    factorial_req_fifo #(
        .WIDTH (IN_DATA_WD),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (disp_if.req_data),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wdog_q      <= '0;
            rsp_data_q  <= '0;
            rsp_arg_q   <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            rsp_data_q  <= rsp_data_d;
            rsp_arg_q   <= rsp_arg_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wdog_d      = wdog_q;
        rsp_data_d  = rsp_data_q;
        rsp_arg_d   = rsp_arg_q;
        rsp_error_d = rsp_error_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !disp_if.core_out_busy) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rsp_arg_d = fifo_head;
                wdog_d    = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                // A result arriving on the expiry cycle still counts as an answer.
                if (disp_if.core_out_valid) begin
                    rsp_data_d  = disp_if.core_out_data;
                    rsp_error_d = 1'b0;
                    state_d     = HOLD;
                end else begin
                    wdog_d = wdog_q + WD_WD'(1);
                    if (wdog_d == WD_LIMIT) begin
                        rsp_data_d  = '0;
                        rsp_error_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (disp_if.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The last issued argument is always the one latched into rsp_arg_q.
    always_comb begin
        disp_if.core_in_valid = (state_q == ISSUE);
        disp_if.core_in_data  = (state_q == ISSUE) ? fifo_head : rsp_arg_q;
        disp_if.rsp_valid     = (state_q == HOLD);
        disp_if.rsp_data      = rsp_data_q;
        disp_if.rsp_arg       = rsp_arg_q;
        disp_if.rsp_error     = rsp_error_q;
        disp_if.req_ready     = !fifo_full;
        disp_if.count         = fifo_count;
    end
endmodule
`default_nettype wire

// File: tb/tb_factorial_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_factorial_dispatcher
// Description : Scoreboard bench with a behavioural core and factorial model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_factorial_dispatcher;
    localparam int IW      = 3;
    localparam int OW      = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    typedef struct packed {
        logic [IW-1:0] arg;
        logic [OW-1:0] data;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [IW-1:0] req_data   = '0;
    logic          req_valid  = 1'b0;
    logic          rsp_ready  = 1'b1;
    logic          cm_valid   = 1'b0;
    logic          cm_busy    = 1'b0;
    logic [OW-1:0] cm_data    = '0;
    logic          spur_valid = 1'b0;
    logic [OW-1:0] spur_data  = '0;
    logic          force_busy = 1'b0;
    logic          mute       = 1'b0;
    int            cm_lat_fixed = 6;
    logic          rdy_rand   = 1'b0;
    logic          rdy_val    = 1'b1;

    exp_t        exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    factorial_dispatcher_if #(.IN_DATA_WD(IW), .OUT_DATA_WD(OW), .DEPTH(DEPTH)) dif ();

    assign dif.req_data       = req_data;
    assign dif.req_valid      = req_valid;
    assign dif.rsp_ready      = rsp_ready;
    assign dif.core_out_valid = cm_valid | spur_valid;
    assign dif.core_out_data  = spur_valid ? spur_data : cm_data;
    assign dif.core_out_busy  = cm_busy | force_busy;

    factorial_dispatcher #(
        .IN_DATA_WD  (IW),
        .OUT_DATA_WD (OW),
        .DEPTH       (DEPTH),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .disp_if (dif)
    );

    function automatic logic [OW-1:0] fact(input int n);
        int unsigned p;
        p = 1;
        for (int k = 2; k <= n; k++) p = p * k;
        return p[OW-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called right after a rising edge; returns one ns after the accepting edge.
    task automatic push_req(input logic [IW-1:0] n);
        exp_t e;
        int   c;
        c = 0;
        req_valid = 1'b1;
        req_data  = n;
        @(negedge clk);
        while (!dif.req_ready && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("req_accept_bound", 32'(c >= 500), 32'd0);
        @(posedge clk);
        e.arg  = n;
        e.data = mute ? '0 : fact(int'(n));
        e.err  = mute;
        exp_q.push_back(e);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || dif.rsp_valid || dif.count != '0) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk(name, 32'(c >= maxc), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_civ(input string name);
        int c;
        c = 0;
        @(negedge clk);
        while (!dif.core_in_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk(name, 32'(c >= 100), 32'd0);
    endtask

    // rsp_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    // Behavioural factorial core: busy after a start, result after lat cycles.
    initial begin
        int            lat;
        logic [IW-1:0] n;
        forever begin
            @(negedge clk);
            if (!reset && dif.core_in_valid && !mute) begin
                n   = dif.core_in_data;
                lat = (cm_lat_fixed > 0) ? cm_lat_fixed : int'($urandom_range(1, 8));
                @(posedge clk);
                #1 cm_busy = 1'b1;
                repeat (lat - 1) @(posedge clk);
                #1;
                cm_valid = 1'b1;
                cm_data  = fact(int'(n));
                cm_busy  = 1'b0;
                @(posedge clk);
                #1 cm_valid = 1'b0;
            end
        end
    end

    // Response monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("req_ready_vs_count", 32'(dif.req_ready), 32'(dif.count != 3'(DEPTH)));
                if (dif.rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_rsp: actual arg=%0d data=%0d err=%0b, required no response",
                                 dif.rsp_arg, dif.rsp_data, dif.rsp_error);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_arg",   32'(dif.rsp_arg),   32'(e.arg));
                        chk("rsp_data",  32'(dif.rsp_data),  32'(e.data));
                        chk("rsp_error", 32'(dif.rsp_error), 32'(e.err));
                    end
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int c;
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req_ready",     32'(dif.req_ready),     32'd1);
        chk("rst_core_in_valid", 32'(dif.core_in_valid), 32'd0);
        chk("rst_core_in_data",  32'(dif.core_in_data),  32'd0);
        chk("rst_rsp_valid",     32'(dif.rsp_valid),     32'd0);
        chk("rst_rsp_data",      32'(dif.rsp_data),      32'd0);
        chk("rst_rsp_arg",       32'(dif.rsp_arg),       32'd0);
        chk("rst_rsp_error",     32'(dif.rsp_error),     32'd0);
        chk("rst_count",         32'(dif.count),         32'd0);
        step();
        reset = 1'b0;

        // Single request n=5, core answers after 6 cycles
        step();
        cm_lat_fixed = 6;
        push_req(3'd5);
        @(negedge clk);
        chk("issue_lat_n1", 32'(dif.core_in_valid), 32'd0);
        @(negedge clk);
        chk("issue_lat_n2",   32'(dif.core_in_valid), 32'd1);
        chk("issue_data",     32'(dif.core_in_data),  32'd5);
        c = 0;
        while (!cm_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("core_answer_bound", 32'(c >= 20), 32'd0);
        chk("rsp_before_m1", 32'(dif.rsp_valid), 32'd0);
        @(negedge clk);
        chk("rsp_at_m1", 32'(dif.rsp_valid), 32'd1);
        wait_idle("single_done", 50);
        chk("core_in_data_hold", 32'(dif.core_in_data), 32'd5);

        // Back-to-back 0,1,7,3
        step();
        cm_lat_fixed = 3;
        push_req(3'd0);
        push_req(3'd1);
        push_req(3'd7);
        push_req(3'd3);
        wait_idle("b2b_done", 200);

        // FIFO full with simultaneous pop
        step();
        force_busy = 1'b1;
        push_req(3'd2);
        push_req(3'd3);
        push_req(3'd4);
        push_req(3'd5);
        @(negedge clk);
        chk("full_count",     32'(dif.count),     32'd4);
        chk("full_req_ready", 32'(dif.req_ready), 32'd0);
        step();
        req_valid  = 1'b1;
        req_data   = 3'd6;
        force_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("full_issue",      32'(dif.core_in_valid), 32'd1);
        chk("full_issue_data", 32'(dif.core_in_data),  32'd2);
        chk("full_pop_count",  32'(dif.count),         32'd4);
        chk("full_pop_ready",  32'(dif.req_ready),     32'd0);
        @(negedge clk);
        chk("after_pop_count", 32'(dif.count),     32'd3);
        chk("after_pop_ready", 32'(dif.req_ready), 32'd1);
        @(posedge clk);
        exp_q.push_back('{arg: 3'd6, data: fact(6), err: 1'b0});
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("fifth_accepted", 32'(dif.count), 32'd4);
        wait_idle("full_done", 400);

        // Response stall with spurious core strobes
        step();
        rdy_val = 1'b0;
        step();
        step();
        push_req(3'd2);
        push_req(3'd3);
        c = 0;
        while (!dif.rsp_valid && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("stall_rsp_bound", 32'(c >= 50), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            spur_valid = (i % 2 == 0);
            spur_data  = OW'($urandom);
            @(negedge clk);
            chk("stall_rsp_valid", 32'(dif.rsp_valid),     32'd1);
            chk("stall_rsp_data",  32'(dif.rsp_data),      32'(fact(2)));
            chk("stall_rsp_arg",   32'(dif.rsp_arg),       32'd2);
            chk("stall_rsp_error", 32'(dif.rsp_error),     32'd0);
            chk("stall_no_issue",  32'(dif.core_in_valid), 32'd0);
            chk("stall_count",     32'(dif.count),         32'd1);
        end
        step();
        spur_valid = 1'b0;
        rdy_val    = 1'b1;
        wait_idle("stall_done", 100);

        // Watchdog timeout for n=4
        step();
        mute = 1'b1;
        push_req(3'd4);
        wait_civ("timeout_issue_bound");
        c = 0;
        while (!dif.rsp_valid && c < TIMEOUT + 10) begin
            @(negedge clk);
            c++;
        end
        chk("timeout_latency", 32'(c), 32'(TIMEOUT + 1));
        chk("timeout_error",   32'(dif.rsp_error), 32'd1);
        wait_idle("timeout_done", 20);
        mute = 1'b0;

        // Randomized traffic with random backpressure and core latency
        step();
        cm_lat_fixed = 0;
        rdy_rand     = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) step();
            push_req(IW'($urandom_range(0, 7)));
        end
        rdy_rand = 1'b0;
        rdy_val  = 1'b1;
        wait_idle("random_done", 2000);

        // Reset during WAIT with three entries queued
        step();
        mute = 1'b1;
        push_req(3'd1);
        wait_civ("rst_issue_bound");
        step();
        push_req(3'd5);
        push_req(3'd6);
        push_req(3'd7);
        @(negedge clk);
        chk("pre_reset_count", 32'(dif.count), 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_req_ready",     32'(dif.req_ready),     32'd1);
        chk("mid_rst_core_in_valid", 32'(dif.core_in_valid), 32'd0);
        chk("mid_rst_core_in_data",  32'(dif.core_in_data),  32'd0);
        chk("mid_rst_rsp_valid",     32'(dif.rsp_valid),     32'd0);
        chk("mid_rst_rsp_data",      32'(dif.rsp_data),      32'd0);
        chk("mid_rst_rsp_arg",       32'(dif.rsp_arg),       32'd0);
        chk("mid_rst_rsp_error",     32'(dif.rsp_error),     32'd0);
        chk("mid_rst_count",         32'(dif.count),         32'd0);
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
        mute  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp",   32'(dif.rsp_valid),     32'd0);
            chk("post_rst_no_issue", 32'(dif.core_in_valid), 32'd0);
            chk("post_rst_count",    32'(dif.count),         32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/factorial_dispatcher.md
# factorial_dispatcher

Request dispatcher placed directly in front of the factorial core. Buffers incoming factorial arguments in a small FIFO and issues them to the core one at a time, respecting the core's `out_busy`. Captures each core result and returns it, tagged with its argument, on a valid/ready response port. A watchdog flags a core that never answers.

## Interface
Parameters:
- `IN_DATA_WD`, 3: argument width; matches the core's `in_data`.
- `OUT_DATA_WD`, 16: result width; matches the core's `out_data`.
- `DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `TIMEOUT`, 64: maximum cycles to wait for `core_out_valid`; ≥2.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_data` in IN_DATA_WD: argument n.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO can accept.
- `core_in_data` out IN_DATA_WD: argument to the core.
- `core_in_valid` out 1: one-cycle start pulse to the core.
- `core_out_data` in OUT_DATA_WD: core result.
- `core_out_valid` in 1: core result strobe.
- `core_out_busy` in 1: core computing.
- `rsp_data` out OUT_DATA_WD: n! result (0 on error).
- `rsp_arg` out IN_DATA_WD: argument that produced the result.
- `rsp_error` out 1: timeout flag, qualified by `rsp_valid`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts.
- `count` out $clog2(DEPTH+1): FIFO occupancy.

## Operation
- FIFO behaviour:
  - Push when `req_valid && req_ready`.
  - `req_ready = (count != DEPTH)`. It is not raised by a same-cycle pop when full.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, HOLD. Only one request is outstanding at a time.
- IDLE:
  - Go to ISSUE when `count != 0 && !core_out_busy`.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - `core_in_valid=1` and `core_in_data` = FIFO head.
  - Pop the head and latch it into `rsp_arg`.
  - Clear the watchdog and go to WAIT.
- WAIT:
  - On `core_out_valid`: latch `core_out_data` into `rsp_data`, set `rsp_error=0`, go to HOLD.
  - Otherwise increment the watchdog. When it reaches TIMEOUT: `rsp_data=0`, `rsp_error=1`, go to HOLD.
  - `core_out_valid` on the same cycle as the timeout wins; no error is reported.
- HOLD:
  - `rsp_valid=1`. `rsp_data`, `rsp_arg` and `rsp_error` are stable until accepted.
  - On `rsp_valid && rsp_ready`, go to IDLE.
- `core_out_valid` outside WAIT is ignored; no state change.
- A push and a pop in the same cycle leave `count` unchanged.
- `core_in_data` holds its last value outside ISSUE.

## Timing
- Reset values:
  - `req_ready=1`, `core_in_valid=0`, `core_in_data=0`.
  - `rsp_valid=0`, `rsp_data=0`, `rsp_arg=0`, `rsp_error=0`.
  - `count=0`, state IDLE, watchdog 0.
- Reset mid-operation flushes the FIFO and drops any pending result. The core shares the reset.
- Issue latency:
  - Request accepted in cycle N with FIFO empty, IDLE, core idle → `core_in_valid` in cycle N+2.
  - If `core_out_busy` is high, issue happens 1 cycle after busy falls.
- Response latency: `core_out_valid` in cycle M → `rsp_valid` in cycle M+1.
- Back-to-back: earliest next `core_in_valid` is 2 cycles after the response handshake (HOLD→IDLE→ISSUE).
- `rsp_valid` never drops without a handshake.

## Structure
- `factorial_pkg` holds:
  - the `disp_state_e` enum (IDLE/ISSUE/WAIT/HOLD);
  - default width constants `IN_DATA_WD=3` and `OUT_DATA_WD=16`;
  - a `factorial_ref(n)` function for benches.
- One sub-module: `factorial_req_fifo`, a parameterised synchronous FIFO exposing push/pop/head/count/full/empty.
- FSM and watchdog sit in `factorial_dispatcher`.

## Test plan
- Reset, then single request n=5, core answers 120 after 6 cycles → `core_in_valid` at N+2 with data 5; `rsp_valid` with `rsp_data=120`, `rsp_arg=5`, `rsp_error=0`.
- Push 0,1,7,3 back-to-back with `rsp_ready=1` → four responses in order: 1, 1, 5040, 6. `req_ready` drops only when `count=4`.
- FIFO full (DEPTH=4) with `req_valid` held high and a same-cycle pop → no push that cycle; `count` goes 4→3; the fifth request is accepted the next cycle.
- Core never asserts `core_out_valid` for n=4 → after TIMEOUT=64 cycles: `rsp_valid=1`, `rsp_error=1`, `rsp_data=0`, `rsp_arg=4`.
- `rsp_ready=0` for 10 cycles while the core pulses a spurious `core_out_valid` → response value unchanged, no new `core_in_valid`.
- Assert `reset` during WAIT with 3 entries queued → all outputs at reset values, `count=0`, and no response emitted after release.
